pocket_event_arbiter: RTL and testbench

//  Collects pocketing events from the per-ball hole-collision detectors (NUM_BALLS instances), queues them
//  and serialises them, one at a time, to the shared score/turn unit via a valid/ready handshake.

---
 rtl/pocket_event_arbiter_pkg.sv | 12 +
 rtl/pocket_event_arbiter_if.sv | 15 +
 rtl/pocket_event_arbiter_rr.sv | 30 +++
 rtl/pocket_event_arbiter.sv | 160 ++++++++++++++++
 tb/tb_pocket_event_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pocket_event_arbiter_pkg.sv
// Shared types and helpers for the pocket event arbiter slice.
package pocket_pkg;

    typedef enum logic [1:0] {IDLE, OFFER, SETTLE, RESPAWN} pocket_state_t;

    localparam int CUE_BALL = 0;

    function automatic int ball_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pocket_event_arbiter_if.sv
// Valid/ready event channel from the arbiter to the score/turn unit.
interface pocket_event_arbiter_if #(
    parameter int BALL_W = 4,
    parameter int HOLE_W = 3
) ();

    logic              pocketValid;
    logic              pocketReady;
    logic [BALL_W-1:0] pocketBall;
    logic [HOLE_W-1:0] pocketHole;

    modport master (output pocketValid, output pocketBall, output pocketHole, input pocketReady);
    modport slave  (input pocketValid, input pocketBall, input pocketHole, output pocketReady);

endinterface

// File: rtl/pocket_event_arbiter_rr.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter
    import pocket_pkg::*;
#(
    parameter  int N     = 16,
    localparam int IDX_W = ball_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    always_comb begin
        int j;
        j         = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        // Scan from the farthest offset down so the nearest request wins last.
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (req[IDX_W'(j)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/pocket_event_arbiter.sv
// Captures per-ball pocket pulses, serialises them round-robin to the score unit,
// hides pocketed balls and sequences cue-ball respawn after a frame-counted settle.
module pocket_event_arbiter
    import pocket_pkg::*;
#(
    parameter  int NUM_BALLS     = 16,
    parameter  int HOLE_W        = 3,
    parameter  int SETTLE_FRAMES = 8,
    localparam int BALL_W        = ball_w(NUM_BALLS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          startOfFrame,
    input  logic [NUM_BALLS-1:0]          holeHit,
    input  logic [NUM_BALLS*HOLE_W-1:0]   holeNumberHit,
    input  logic                          clearAll,
    pocket_event_arbiter_if.master        pocket,
    output logic                          respawnReq,
    input  logic                          respawnAck,
    output logic [NUM_BALLS-1:0]          ballHide,
    output logic                          busy
);

    localparam int CNT_W = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;

    pocket_state_t         state_q, state_d;
    logic [NUM_BALLS-1:0]  pending_q, pending_d;
    logic [NUM_BALLS-1:0]  hide_q, hide_d;
    logic [HOLE_W-1:0]     hole_q [NUM_BALLS];
    logic [HOLE_W-1:0]     hole_d [NUM_BALLS];
    logic [BALL_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BALL_W-1:0]     ball_q, ball_d;
    logic [HOLE_W-1:0]     hole_out_q, hole_out_d;
    logic                  valid_q, valid_d;
    logic                  respawn_q, respawn_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [NUM_BALLS-1:0]  cap;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  settle_done;
    logic                  gnt_valid;
    logic [BALL_W-1:0]     gnt_idx;

    rr_arbiter #(.N(NUM_BALLS)) u_rr (
        .req       (pending_q),
        .ptr       (rr_ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        ball_d     = ball_q;
        hole_out_d = hole_out_q;
        valid_d    = valid_q;
        respawn_d  = respawn_q;
        cnt_d      = cnt_q;
        hole_d     = hole_q;

        cap         = holeHit & ~hide_q;
        cnt_inc     = cnt_q + CNT_W'(1);
        settle_done = (SETTLE_FRAMES == 0) ||
                      (startOfFrame && (cnt_inc == CNT_W'(SETTLE_FRAMES)));

        pending_d = pending_q | cap;
        hide_d    = hide_q | cap;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (cap[i]) hole_d[i] = holeNumberHit[i*HOLE_W +: HOLE_W];
        end

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    pending_d[gnt_idx] = 1'b0;
                    ball_d     = gnt_idx;
                    hole_out_d = hole_q[gnt_idx];
                    rr_ptr_d   = (gnt_idx == BALL_W'(NUM_BALLS - 1)) ? '0 : gnt_idx + BALL_W'(1);
                    valid_d    = 1'b1;
                    state_d    = OFFER;
                end
            end
            OFFER: begin
                if (pocket.pocketReady) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_done) begin
                    cnt_d = '0;
                    if (ball_q == BALL_W'(CUE_BALL)) begin
                        respawn_d = 1'b1;
                        state_d   = RESPAWN;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (startOfFrame) begin
                    cnt_d = cnt_inc;
                end
            end
            RESPAWN: begin
                if (respawnAck) begin
                    respawn_d        = 1'b0;
                    hide_d[CUE_BALL] = 1'b0;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // New rack wins over everything, but the fairness pointer survives it.
        if (clearAll) begin
            pending_d  = '0;
            hide_d     = '0;
            state_d    = IDLE;
            valid_d    = 1'b0;
            respawn_d  = 1'b0;
            cnt_d      = '0;
            ball_d     = '0;
            hole_out_d = '0;
            rr_ptr_d   = rr_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            hide_q     <= '0;
            hole_q     <= '{default: '0};
            rr_ptr_q   <= '0;
            ball_q     <= '0;
            hole_out_q <= '0;
            valid_q    <= 1'b0;
            respawn_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            hide_q     <= hide_d;
            hole_q     <= hole_d;
            rr_ptr_q   <= rr_ptr_d;
            ball_q     <= ball_d;
            hole_out_q <= hole_out_d;
            valid_q    <= valid_d;
            respawn_q  <= respawn_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pocket.pocketValid = valid_q;
    assign pocket.pocketBall  = ball_q;
    assign pocket.pocketHole  = hole_out_q;
    assign respawnReq         = respawn_q;
    assign ballHide           = hide_q;
    assign busy               = (state_q != IDLE) || (|pending_q);

endmodule

// File: tb/tb_pocket_event_arbiter.sv
// Directed bench for pocket_event_arbiter with a scoreboard of expected transfers.
module tb_pocket_event_arbiter;
    localparam int NB = 16;
    localparam int HW = 3;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          startOfFrame = 1'b0;
    logic [NB-1:0] holeHit = '0;
    logic [NB*HW-1:0] holeNumberHit = '0;
    logic          clearAll = 1'b0;
    logic          respawnReq;
    logic          respawnAck = 1'b0;
    logic [NB-1:0] ballHide;
    logic          busy;

    pocket_event_arbiter_if #(.BALL_W(BW), .HOLE_W(HW)) pk ();

    pocket_event_arbiter #(.NUM_BALLS(NB), .HOLE_W(HW), .SETTLE_FRAMES(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (startOfFrame),
        .holeHit       (holeHit),
        .holeNumberHit (holeNumberHit),
        .clearAll      (clearAll),
        .pocket        (pk.master),
        .respawnReq    (respawnReq),
        .respawnAck    (respawnAck),
        .ballHide      (ballHide),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [BW+HW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            startOfFrame = 1'b1;
            cyc(1);
            startOfFrame = 1'b0;
            cyc(1);
        end
    endtask

    task automatic set_hit(input int b, input logic [HW-1:0] h);
        holeHit[b] = 1'b1;
        holeNumberHit[b*HW +: HW] = h;
    endtask

    task automatic push_exp(input int b, input logic [HW-1:0] h);
        logic [BW-1:0] bb;
        bb = BW'(b);
        exp_q.push_back({bb, h});
    endtask

    task automatic wait_valid();
        int n = 0;
        while (pk.pocketValid !== 1'b1 && n < 100) begin
            cyc(1);
            n++;
        end
        chk("wait_valid", 32'(pk.pocketValid), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            cyc(1);
            n++;
        end
        chk("wait_idle", 32'(busy), 32'd0);
    endtask

    // Scoreboard: every transfer must match the oldest expected event.
    always @(negedge clk) begin
        if (!reset && pk.pocketValid === 1'b1 && pk.pocketReady === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected observed=%0h expected=none", {pk.pocketBall, pk.pocketHole});
            end
            if (exp_q.size() != 0) begin
                logic [BW+HW-1:0] e;
                e = exp_q.pop_front();
                checks++;
                assert ({pk.pocketBall, pk.pocketHole} === e) else begin
                    errors++;
                    $error("FAIL sb_event observed=%0h expected=%0h", {pk.pocketBall, pk.pocketHole}, e);
                end
            end
        end
    end

    initial begin
        pk.pocketReady = 1'b0;
        cyc(2);
        chk("rst_valid", 32'(pk.pocketValid), 0);
        chk("rst_hide", 32'(ballHide), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_resp", 32'(respawnReq), 0);
        reset = 1'b0;

        // 1: single event, two-cycle latency
        pk.pocketReady = 1'b1;
        set_hit(5, 3'd3);
        push_exp(5, 3'd3);
        cyc(1);
        holeHit = '0;
        chk("t1_hide", 32'(ballHide), 32'h0020);
        chk("t1_valid_t1", 32'(pk.pocketValid), 0);
        cyc(1);
        chk("t1_valid_t2", 32'(pk.pocketValid), 1);
        chk("t1_ball", 32'(pk.pocketBall), 5);
        chk("t1_hole", 32'(pk.pocketHole), 3);
        cyc(1);
        chk("t1_valid_drop", 32'(pk.pocketValid), 0);
        frames(8);
        wait_idle();

        // advance rrPtr to 8 via ball 7, then new rack
        set_hit(7, 3'd1);
        push_exp(7, 3'd1);
        cyc(1);
        holeHit = '0;
        wait_valid();
        cyc(1);
        frames(8);
        wait_idle();
        clearAll = 1'b1;
        cyc(1);
        clearAll = 1'b0;
        chk("clr_hide", 32'(ballHide), 0);

        // 2: fairness from rrPtr=8
        set_hit(2, 3'd4);
        set_hit(7, 3'd5);
        set_hit(12, 3'd6);
        push_exp(12, 3'd6);
        push_exp(2, 3'd4);
        push_exp(7, 3'd5);
        cyc(1);
        holeHit = '0;
        chk("t2_hide", 32'(ballHide), 32'h1084);
        repeat (3) begin
            wait_valid();
            cyc(1);
            frames(8);
        end
        wait_idle();
        chk("t2_drained", exp_q.size(), 0);

        // 3: backpressure
        pk.pocketReady = 1'b0;
        set_hit(9, 3'd2);
        push_exp(9, 3'd2);
        cyc(1);
        holeHit = '0;
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_valid", 32'(pk.pocketValid), 1);
            chk("t3_hold_ball", 32'(pk.pocketBall), 9);
            chk("t3_hold_hole", 32'(pk.pocketHole), 2);
            cyc(1);
        end
        pk.pocketReady = 1'b1;
        cyc(1);
        chk("t3_accepted", 32'(pk.pocketValid), 0);
        chk("t3_drained", exp_q.size(), 0);
        frames(8);
        wait_idle();

        // 4: cue ball respawn
        set_hit(0, 3'd7);
        push_exp(0, 3'd7);
        cyc(1);
        holeHit = '0;
        wait_valid();
        cyc(1);
        set_hit(0, 3'd5);
        cyc(1);
        holeHit = '0;
        frames(7);
        chk("t4_resp_before", 32'(respawnReq), 0);
        startOfFrame = 1'b1;
        cyc(1);
        startOfFrame = 1'b0;
        chk("t4_resp_rise", 32'(respawnReq), 1);
        cyc(3);
        chk("t4_resp_hold", 32'(respawnReq), 1);
        chk("t4_hide0", 32'(ballHide[0]), 1);
        respawnAck = 1'b1;
        cyc(1);
        respawnAck = 1'b0;
        chk("t4_resp_fall", 32'(respawnReq), 0);
        chk("t4_unhide0", 32'(ballHide[0]), 0);
        chk("t4_no_repeat", 32'(busy), 0);

        // 5: clearAll during OFFER with pending work and a same-cycle hit
        clearAll = 1'b1;
        cyc(1);
        clearAll = 1'b0;
        pk.pocketReady = 1'b0;
        set_hit(3, 3'd1);
        set_hit(4, 3'd2);
        cyc(1);
        holeHit = '0;
        wait_valid();
        chk("t5_offer_ball", 32'(pk.pocketBall), 3);
        set_hit(9, 3'd3);
        clearAll = 1'b1;
        cyc(1);
        clearAll = 1'b0;
        holeHit = '0;
        chk("t5_valid", 32'(pk.pocketValid), 0);
        chk("t5_ball", 32'(pk.pocketBall), 0);
        chk("t5_hole", 32'(pk.pocketHole), 0);
        chk("t5_hide", 32'(ballHide), 0);
        chk("t5_resp", 32'(respawnReq), 0);
        chk("t5_busy", 32'(busy), 0);
        pk.pocketReady = 1'b1;
        cyc(30);
        chk("t5_quiet", 32'(pk.pocketValid), 0);

        // 6: reset while in RESPAWN, then a normal event
        set_hit(0, 3'd2);
        push_exp(0, 3'd2);
        cyc(1);
        holeHit = '0;
        wait_valid();
        cyc(1);
        frames(8);
        chk("t6_in_respawn", 32'(respawnReq), 1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("t6_resp", 32'(respawnReq), 0);
        chk("t6_hide", 32'(ballHide), 0);
        chk("t6_valid", 32'(pk.pocketValid), 0);
        chk("t6_busy", 32'(busy), 0);
        set_hit(5, 3'd3);
        push_exp(5, 3'd3);
        cyc(1);
        holeHit = '0;
        chk("t6_hide5", 32'(ballHide), 32'h0020);
        cyc(1);
        chk("t6_valid2", 32'(pk.pocketValid), 1);
        chk("t6_ball", 32'(pk.pocketBall), 5);
        chk("t6_hole", 32'(pk.pocketHole), 3);
        cyc(1);
        frames(8);
        wait_idle();
        chk("final_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
